// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and message-size constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int VC_MEM_REQ_MSG_SZ  = 67;  // 32-bit addr, 32-bit data
  localparam int VC_MEM_RESP_MSG_SZ = 35;  // 32-bit data

  typedef logic port_id_t;

  localparam port_id_t PORT_IMEM = 1'b0;
  localparam port_id_t PORT_DMEM = 1'b1;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_port_id_queue.sv
// Generic synchronous FIFO; push/pop take effect at posedge, head is visible the cycle after a push.
// A push while full or a pop while empty is ignored; full/empty come from the registered count.
module mem_port_id_queue #(
  parameter int p_width = 1,
  parameter int p_depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [p_width-1:0]         i_push_dat,
  input  logic                       i_pop,
  output logic [p_width-1:0]         o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(p_depth):0]   o_count
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;

  logic [p_width-1:0] r_mem [p_depth];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_full    = (r_count == CW'(p_depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of imem/dmem ports onto one in-order memory port; zero-latency request and response paths.
// Requests stall (both rdy low) when p_max_inflight are outstanding; a response stalls until its owning port is ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int p_req_sz       = VC_MEM_REQ_MSG_SZ,
  parameter int p_resp_sz      = VC_MEM_RESP_MSG_SZ,
  parameter int p_max_inflight = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_req_sz-1:0]               req0_msg,
  input  logic                              req0_val,
  output logic                              req0_rdy,
  output logic [p_resp_sz-1:0]              resp0_msg,
  output logic                              resp0_val,
  input  logic                              resp0_rdy,
  input  logic [p_req_sz-1:0]               req1_msg,
  input  logic                              req1_val,
  output logic                              req1_rdy,
  output logic [p_resp_sz-1:0]              resp1_msg,
  output logic                              resp1_val,
  input  logic                              resp1_rdy,
  output logic [p_req_sz-1:0]               memreq_msg,
  output logic                              memreq_val,
  input  logic                              memreq_rdy,
  input  logic [p_resp_sz-1:0]              memresp_msg,
  input  logic                              memresp_val,
  output logic                              memresp_rdy,
  output logic [$clog2(p_max_inflight):0]   inflight,
  output logic                              err
);

  port_id_t r_prio;
  logic     r_err;
  port_id_t w_grant;
  port_id_t w_head;
  logic     w_fav_val;
  logic     w_oth_val;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;
  logic     w_head_rdy;

  assign w_fav_val = (r_prio == PORT_DMEM) ? req1_val : req0_val;
  assign w_oth_val = (r_prio == PORT_DMEM) ? req0_val : req1_val;
  // With no request pending the favoured port is nominally granted.
  assign w_grant   = (w_fav_val || !w_oth_val) ? r_prio : other_port(r_prio);

  assign memreq_val = (req0_val || req1_val) && !w_full;
  assign memreq_msg = (w_grant == PORT_DMEM) ? req1_msg : req0_msg;
  assign req0_rdy   = (w_grant == PORT_IMEM) && memreq_rdy && !w_full;
  assign req1_rdy   = (w_grant == PORT_DMEM) && memreq_rdy && !w_full;
  assign w_push     = memreq_val && memreq_rdy;

  assign w_head_rdy  = (w_head == PORT_DMEM) ? resp1_rdy : resp0_rdy;
  assign memresp_rdy = !w_empty && w_head_rdy;
  assign resp0_val   = memresp_val && !w_empty && (w_head == PORT_IMEM);
  assign resp1_val   = memresp_val && !w_empty && (w_head == PORT_DMEM);
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign w_pop       = memresp_val && memresp_rdy;
  assign err         = r_err;

  mem_port_id_queue #(
    .p_width ($bits(port_id_t)),
    .p_depth (p_max_inflight)
  ) u_id_queue (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_push_dat (w_grant),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (inflight)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio <= PORT_IMEM;
      r_err  <= 1'b0;
    end else begin
      if (w_push)                  r_prio <= other_port(w_grant);
      if (memresp_val && w_empty)  r_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and randomized traffic against a queue model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int D  = 4;
  localparam int RQ = VC_MEM_REQ_MSG_SZ;
  localparam int RS = VC_MEM_RESP_MSG_SZ;
  localparam int CW = $clog2(D) + 1;

  logic          clk, reset;
  logic [RQ-1:0] req0_msg, req1_msg, memreq_msg;
  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  logic [RS-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [CW-1:0] inflight;
  logic          err;

  mem_port_arbiter #(.p_req_sz(RQ), .p_resp_sz(RS), .p_max_inflight(D)) dut (
    .clk(clk), .reset(reset),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .inflight(inflight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding requests are a list of port IDs in issue order.
  int mq[$];
  bit m_prio, m_err;
  bit e_g, e_mv, e_rdy0, e_rdy1, e_mrr, e_v0, e_v1;

  task automatic model_reset();
    mq.delete();
    m_prio = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_eval();
    bit full, empty, anyv;
    int head;
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    anyv  = req0_val || req1_val;
    head  = empty ? 0 : mq[0];
    if (m_prio) e_g = req1_val ? 1'b1 : (req0_val ? 1'b0 : 1'b1);
    else        e_g = req0_val ? 1'b0 : (req1_val ? 1'b1 : 1'b0);
    e_mv   = anyv && !full;
    e_rdy0 = e_mv && memreq_rdy && (e_g == 1'b0);
    e_rdy1 = e_mv && memreq_rdy && (e_g == 1'b1);
    e_v0   = memresp_val && !empty && (head == 0);
    e_v1   = memresp_val && !empty && (head == 1);
    e_mrr  = !empty && ((head == 1) ? resp1_rdy : resp0_rdy);
  endtask

  task automatic check_model();
    model_eval();
    chk("memreq_val", 128'(memreq_val), 128'(e_mv));
    if (e_mv) chk("memreq_msg", 128'(memreq_msg), e_g ? 128'(req1_msg) : 128'(req0_msg));
    if (req0_val || req1_val) begin
      chk("req0_rdy", 128'(req0_rdy), 128'(e_rdy0));
      chk("req1_rdy", 128'(req1_rdy), 128'(e_rdy1));
    end
    chk("memresp_rdy", 128'(memresp_rdy), 128'(e_mrr));
    chk("resp0_val", 128'(resp0_val), 128'(e_v0));
    chk("resp1_val", 128'(resp1_val), 128'(e_v1));
    if (e_v0) chk("resp0_msg", 128'(resp0_msg), 128'(memresp_msg));
    if (e_v1) chk("resp1_msg", 128'(resp1_msg), 128'(memresp_msg));
    chk("inflight", 128'(inflight), 128'(mq.size()));
    chk("err", 128'(err), 128'(m_err));
  endtask

  task automatic model_commit();
    if (memresp_val && mq.size() == 0) m_err = 1'b1;
    if (memresp_val && e_mrr) void'(mq.pop_front());
    if (e_mv && memreq_rdy) begin
      mq.push_back(int'(e_g));
      m_prio = !e_g;
    end
  endtask

  function automatic logic [RQ-1:0] rnd_req();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[RQ-1:0];
  endfunction

  function automatic logic [RS-1:0] rnd_resp();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RS-1:0];
  endfunction

  task automatic drive(input logic r0v, r1v, mrdy, mrv, rdy0, rdy1);
    req0_val = r0v;  req1_val = r1v;  memreq_rdy = mrdy;
    memresp_val = mrv;  resp0_rdy = rdy0;  resp1_rdy = rdy1;
    req0_msg = rnd_req();  req1_msg = rnd_req();  memresp_msg = rnd_resp();
  endtask

  task automatic settle();
    #2;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  typedef struct {
    logic r0v, r1v, mrdy, mrv, rdy0, rdy1;
    logic mv, g, mrr, v0, v1, q0, q1;
    int   infl;
  } vec_t;

  function automatic vec_t mkvec(input logic [12:0] b, input int infl);
    vec_t v;
    {v.r0v, v.r1v, v.mrdy, v.mrv, v.rdy0, v.rdy1} = b[12:7];
    {v.mv, v.g, v.mrr, v.v0, v.v1, v.q0, v.q1}    = b[6:0];
    v.infl = infl;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    // inputs: r0v r1v mrdy mrv rdy0 rdy1 | expected: mv g mrr v0 v1 req0_rdy req1_rdy | inflight
    tbl[0]  = mkvec(13'b111011_1000010, 0);
    tbl[1]  = mkvec(13'b111011_1110001, 1);
    tbl[2]  = mkvec(13'b111111_1011010, 2);
    tbl[3]  = mkvec(13'b001110_0000100, 2);
    tbl[4]  = mkvec(13'b010111_1110100, 2);
    tbl[5]  = mkvec(13'b101011_1010010, 1);
    tbl[6]  = mkvec(13'b111011_1110001, 2);
    tbl[7]  = mkvec(13'b111011_1010010, 3);
    tbl[8]  = mkvec(13'b111111_0111000, 4);
    tbl[9]  = mkvec(13'b111011_1110001, 3);
    tbl[10] = mkvec(13'b001111_0011000, 4);
    tbl[11] = mkvec(13'b001111_0010100, 3);
    tbl[12] = mkvec(13'b001111_0011000, 2);
    tbl[13] = mkvec(13'b001111_0010100, 1);
    tbl[14] = mkvec(13'b000011_0000000, 0);

    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
    chk("rst_resp_val", 128'({resp0_val, resp1_val}), 128'(0));
    chk("rst_memreq_val", 128'(memreq_val), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    reset = 1'b1;

    // Vector table from reset: alternation, head stall, full, drain.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r0v, tbl[i].r1v, tbl[i].mrdy, tbl[i].mrv, tbl[i].rdy0, tbl[i].rdy1);
      #2;
      chk($sformatf("tbl%0d_memreq_val", i), 128'(memreq_val), 128'(tbl[i].mv));
      if (tbl[i].mv)
        chk($sformatf("tbl%0d_grant_msg", i), 128'(memreq_msg),
            tbl[i].g ? 128'(req1_msg) : 128'(req0_msg));
      chk($sformatf("tbl%0d_memresp_rdy", i), 128'(memresp_rdy), 128'(tbl[i].mrr));
      chk($sformatf("tbl%0d_resp_val", i), 128'({resp0_val, resp1_val}), 128'({tbl[i].v0, tbl[i].v1}));
      if (tbl[i].r0v || tbl[i].r1v)
        chk($sformatf("tbl%0d_req_rdy", i), 128'({req0_rdy, req1_rdy}), 128'({tbl[i].q0, tbl[i].q1}));
      chk($sformatf("tbl%0d_inflight", i), 128'(inflight), 128'(tbl[i].infl));
      check_model();
      tick();
    end

    // Port 0 only: three reads, then three responses back on port 0.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 1, 1);
      req0_msg = RQ'(32'h1000 + 4 * i);
      settle();
      chk("p0_read_addr", 128'(memreq_msg), 128'(32'h1000 + 4 * i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 1);
      settle();
      chk("p0_resp_on_port0", 128'({resp0_val, resp1_val}), 128'(2'b10));
      tick();
    end
    drive(0, 0, 1, 0, 1, 1);
    settle();
    chk("p0_inflight_zero", 128'(inflight), 128'(0));
    tick();

    // Memory withholds responses: fills after 4 grants, one pop frees one grant a cycle later.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, 0, 1, 1);
      settle();
      tick();
    end
    drive(1, 1, 1, 0, 1, 1);
    settle();
    chk("full_inflight", 128'(inflight), 128'(4));
    chk("full_req_rdy", 128'({req0_rdy, req1_rdy}), 128'(0));
    tick();
    drive(1, 1, 1, 1, 1, 1);
    settle();
    chk("full_pop_no_push", 128'(memreq_val), 128'(0));
    chk("full_pop_accepted", 128'(memresp_rdy), 128'(1));
    tick();
    drive(1, 1, 1, 0, 1, 1);
    settle();
    chk("unblocked_grant", 128'(memreq_val), 128'(1));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 1, 1);
      settle();
      tick();
    end

    // Port-1 head with resp1_rdy held low for 3 cycles.
    drive(0, 1, 1, 0, 1, 1);
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      settle();
      chk("hold_memresp_rdy", 128'(memresp_rdy), 128'(0));
      chk("hold_resp_val", 128'({resp0_val, resp1_val}), 128'(2'b01));
      tick();
    end
    drive(0, 0, 1, 1, 1, 1);
    settle();
    chk("release_memresp_rdy", 128'(memresp_rdy), 128'(1));
    tick();

    // Response with empty queue sets sticky err; reset clears it without a clock edge.
    drive(0, 0, 1, 1, 1, 1);
    settle();
    chk("empty_memresp_rdy", 128'(memresp_rdy), 128'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1, 1);
      settle();
      chk("err_sticky", 128'(err), 128'(1));
      tick();
    end
    drive(0, 0, 1, 0, 1, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("err_async_clear", 128'(err), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset with two outstanding: count clears immediately, prio returns to port 0.
    drive(1, 0, 1, 0, 1, 1);
    settle();
    tick();
    drive(0, 1, 1, 0, 1, 1);
    settle();
    tick();
    drive(0, 0, 0, 0, 1, 1);
    #2;
    chk("pre_reset_inflight", 128'(inflight), 128'(2));
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_inflight", 128'(inflight), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 1, 1, 0, 1, 1);
    settle();
    chk("post_reset_prio0", 128'(memreq_msg), 128'(req0_msg));
    tick();
    drive(0, 1, 1, 0, 1, 1);
    settle();
    chk("post_reset_port1", 128'({memreq_val, req1_rdy}), 128'(2'b11));
    tick();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      logic mrv;
      mrv = (mq.size() > 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            mrv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
